// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the execute stage and a word-addressed memory with
// combinational read and clocked write; sub-word stores use read-modify-write.
module lsu_mem_adapter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_write,
    input  logic [31:0]       mem_data,
    output logic [2:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid is a single-cycle completion pulse.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_MERGE  = 3'd2,
        S_ERR    = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         old_q, old_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                accept;
    logic                legal;
    logic [31:0]         byte_word;
    logic [31:0]         half_word;
    logic [31:0]         load_val;
    logic [31:0]         merged;
    logic [4:0]          byte_sh;
    logic [4:0]          half_sh;

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000: legal = 1'b1;
            3'b001: legal = !req_addr[0];
            3'b010: legal = (req_addr[1:0] == 2'b00);
            3'b100: legal = !req_we;
            3'b101: legal = !req_we && !req_addr[0];
            default: legal = 1'b0;
        endcase
        if (req_addr[31:ADDR_W+2] != '0) begin
            legal = 1'b0;
        end
    end

    // Lane extraction and little-endian merge both work on the latched address.
    always_comb begin
        byte_sh   = {addr_q[1:0], 3'b000};
        half_sh   = {addr_q[1], 4'b0000};
        byte_word = mem_data >> byte_sh;
        half_word = mem_data >> half_sh;
        load_val  = mem_data;
        case (f3_q)
            3'b000: load_val = {{24{byte_word[7]}}, byte_word[7:0]};
            3'b001: load_val = {{16{half_word[15]}}, half_word[15:0]};
            3'b100: load_val = {24'h0, byte_word[7:0]};
            3'b101: load_val = {16'h0, half_word[15:0]};
            default: load_val = mem_data;
        endcase
        if (f3_q == 3'b000) begin
            merged = (old_q & ~(32'h0000_00FF << byte_sh)) | ({24'h0, wdata_q[7:0]} << byte_sh);
        end else begin
            merged = (old_q & ~(32'h0000_FFFF << half_sh)) | ({16'h0, wdata_q[15:0]} << half_sh);
        end
    end

    always_comb begin
        accept  = req_valid && (state_q == S_IDLE);
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    state_d = legal ? S_ACCESS : S_ERR;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_val;
                    state_d = S_RESP;
                end else if (f3_q == 3'b010) begin
                    state_d = S_RESP;
                end else begin
                    old_d   = mem_data;
                    state_d = S_MERGE;
                end
            end
            S_MERGE: state_d = S_RESP;
            S_ERR:   state_d = S_IDLE;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
        end
    end

    // Write strobe comes straight from state so reset kills a pending write at once.
    always_comb begin
        mem_write = ((state_q == S_ACCESS) && we_q && (f3_q == 3'b010)) || (state_q == S_MERGE);
        if (state_q == S_MERGE) begin
            mem_write_data = merged;
        end else if (mem_write) begin
            mem_write_data = wdata_q;
        end else begin
            mem_write_data = '0;
        end
    end

    assign mem_addr   = addr_q[ADDR_W+1:2];
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
    assign resp_err   = (state_q == S_ERR);
    assign resp_rdata = rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Bench for lsu_mem_adapter: behavioural word memory, request driver, and a
// response monitor checking data, error flag, latency and write-strobe count.
module tb_lsu_mem_adapter;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic              mem_write;
    logic [31:0]       mem_data;
    logic [2:0]        dbg_state;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;

    int checks;
    int errors;
    int cyc;
    int wr_cnt;

    logic [32:0] exp_q[$];
    int          lat_q[$];
    int          wr_q[$];
    int          acc_q[$];

    lsu_mem_adapter #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_data       (mem_data),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // word memory: combinational read, write on rising edge
    assign mem_data = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_write_data;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int widx, input logic [31:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = widx[ADDR_W-1:0];
        pl_data = data;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // driver: leaves req_valid high on return so requests can run back-to-back
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_rdata, input int exp_lat, input int exp_wr);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
        end else begin
            exp_q.push_back({exp_err, exp_rdata});
            lat_q.push_back(exp_lat);
            wr_q.push_back(exp_wr);
            acc_q.push_back(cyc + 1);
            @(posedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete(); lat_q.delete(); wr_q.delete(); acc_q.delete();
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    // scoreboard monitor
    initial wr_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_cnt = 0;
        end else begin
            if (mem_write) wr_cnt++;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding");
                end else begin
                    logic [32:0] e;
                    int lat;
                    int acc;
                    int ew;
                    e   = exp_q.pop_front();
                    lat = lat_q.pop_front();
                    ew  = wr_q.pop_front();
                    acc = acc_q.pop_front();
                    check("resp_rdata", resp_rdata, e[31:0]);
                    check("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
                    check("resp_latency", 32'(cyc - acc + 1), 32'(lat));
                    check("mem_write_cycles", 32'(wr_cnt), 32'(ew));
                end
                wr_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        pl_en      = 1'b0;
        pl_addr    = '0;
        pl_data    = '0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        check("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
        check("rst_mem_write_data", mem_write_data, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);

        preload(0, 32'h1122_3344);
        preload(1, 32'h5566_7788);
        preload(2, 32'hA5A5_A5A5);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset asserted while the SB write is pending
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h8;
        req_wdata  = 32'h55;
        n = 0;
        while (!mem_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midsb_write_seen", {31'h0, mem_write}, 32'h1);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midsb_write_dropped", {31'h0, mem_write}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("midsb_mem_unchanged", mem[2], 32'hA5A5_A5A5);
        rst_n = 1'b1;
        @(negedge clk);
        check("midsb_req_ready", {31'h0, req_ready}, 32'h1);
        check("midsb_resp_valid", {31'h0, resp_valid}, 32'h0);

        // SW then LW
        issue(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1);
        drain();
        check("sw_mem_word2", mem[2], 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0);

        // sub-word loads
        issue(1'b0, 3'b000, 32'h9, 32'h0, 1'b0, 32'hFFFF_FFBE, 2, 0);
        issue(1'b0, 3'b100, 32'h9, 32'h0, 1'b0, 32'h0000_00BE, 2, 0);
        issue(1'b0, 3'b001, 32'hA, 32'h0, 1'b0, 32'hFFFF_DEAD, 2, 0);
        issue(1'b0, 3'b101, 32'hA, 32'h0, 1'b0, 32'h0000_DEAD, 2, 0);
        issue(1'b0, 3'b000, 32'h8, 32'h0, 1'b0, 32'hFFFF_FFEF, 2, 0);
        drain();

        // sub-word stores
        issue(1'b1, 3'b000, 32'hB, 32'h0000_0012, 1'b0, 32'h0, 3, 1);
        drain();
        check("sb_mem_word2", mem[2], 32'h12AD_BEEF);
        issue(1'b1, 3'b001, 32'h8, 32'h0000_CAFE, 1'b0, 32'h0, 3, 1);
        drain();
        check("sh_mem_word2", mem[2], 32'h12AD_CAFE);

        // rejected accesses
        issue(1'b0, 3'b010, 32'h6, 32'h0, 1'b1, 32'h0, 1, 0);
        issue(1'b1, 3'b001, 32'h3, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 0);
        issue(1'b0, 3'b011, 32'h8, 32'h0, 1'b1, 32'h0, 1, 0);
        issue(1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 0);
        issue(1'b1, 3'b010, 32'h4000, 32'h1111_1111, 1'b1, 32'h0, 1, 0);
        drain();
        check("err_mem_word0", mem[0], 32'h1122_3344);
        check("err_mem_word1", mem[1], 32'h5566_7788);
        check("err_mem_word2", mem[2], 32'h12AD_CAFE);

        // back-to-back with req_valid held high
        issue(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h1122_3344, 2, 0);
        issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h5566_7788, 2, 0);
        issue(1'b1, 3'b000, 32'h1, 32'h0000_00AB, 1'b0, 32'h0, 3, 1);
        drain();
        check("b2b_mem_word0", mem[0], 32'h1122_AB44);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
